rtc_refresh_sequencer: RTL and testbench

- Writer side of the display register bank that the character generator reads through `posicion`, `data_out` and `control_dato_lectura`.
- Once per frame, on the falling edge of `v_sync`, it fetches nine time, date and timer bytes from the RTC bus controller over a req/ack handshake.
- It optionally converts the hour to 12h format with a PM flag, then writes each byte into bank positions 0–8.
- It sits between the RTC bus controller and the character generator, and skips the field group currently being edited.

---
 rtl/rtc_refresh_sequencer.sv | 149 ++++++++++++++
 tb/tb_rtc_refresh_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_refresh_sequencer.sv
// Once-per-frame refresher of the 9-byte display bank: fetches time, date and timer bytes from
// the RTC over a req/ack handshake during vertical blanking and writes them to positions 0-8.
module rtc_refresh_sequencer #(
  parameter int         ACK_TIMEOUT = 255,
  parameter logic [7:0] ADDR_SEG    = 8'h21,
  parameter logic [7:0] ADDR_MIN    = 8'h22,
  parameter logic [7:0] ADDR_HORA   = 8'h23,
  parameter logic [7:0] ADDR_ANIO   = 8'h26,
  parameter logic [7:0] ADDR_MES    = 8'h25,
  parameter logic [7:0] ADDR_DIA    = 8'h24,
  parameter logic [7:0] ADDR_TSEG   = 8'h41,
  parameter logic [7:0] ADDR_TMIN   = 8'h42,
  parameter logic [7:0] ADDR_THORA  = 8'h43
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       v_sync,
  input  logic       sw_formato,
  input  logic [1:0] FSMedit,
  input  logic       rtc_ack,
  input  logic [7:0] rtc_rdata,
  output logic       rtc_req,
  output logic [7:0] rtc_addr,
  output logic [3:0] posicion,
  output logic [7:0] data_out,
  output logic       control_dato_lectura,
  output logic       busy,
  output logic       frame_done,
  output logic       rtc_err
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, SEL, REQ, WRITE, NEXT, DONE} state_t;

  state_t        state, state_nxt;
  logic [3:0]    idx;
  logic [TW-1:0] timer;
  logic          vs_p0, vs_p1;
  logic          abort_q;
  logic          fall, abort_now, skip, timeout;

  function automatic logic [7:0] addr_of(input logic [3:0] i);
    case (i)
      4'd0:    addr_of = ADDR_SEG;
      4'd1:    addr_of = ADDR_MIN;
      4'd2:    addr_of = ADDR_HORA;
      4'd3:    addr_of = ADDR_ANIO;
      4'd4:    addr_of = ADDR_MES;
      4'd5:    addr_of = ADDR_DIA;
      4'd6:    addr_of = ADDR_TSEG;
      4'd7:    addr_of = ADDR_TMIN;
      default: addr_of = ADDR_THORA;
    endcase
  endfunction

  function automatic logic in_edit(input logic [1:0] grp, input logic [3:0] i);
    case (grp)
      2'd3:    in_edit = (i <= 4'd2);
      2'd2:    in_edit = (i >= 4'd3) && (i <= 4'd5);
      2'd1:    in_edit = (i >= 4'd6);
      default: in_edit = 1'b0;
    endcase
  endfunction

  // Only the hours byte is reformatted; out-of-range hours pass through with the PM bit cleared.
  function automatic logic [7:0] conv(input logic [3:0] i, input logic [7:0] b, input logic fmt);
    logic [5:0] h;
    logic [5:0] m;
    logic       tens;
    logic [3:0] ones;
    conv = b;
    if (i == 4'd2) begin
      if (!fmt || (b > 8'h23)) begin
        conv = {1'b0, b[6:0]};
      end else begin
        h    = 6'(b[5:4]) * 6'd10 + 6'(b[3:0]);
        m    = (h >= 6'd12) ? h - 6'd12 : h;
        m    = (m == 6'd0) ? 6'd12 : m;
        tens = (m >= 6'd10);
        ones = tens ? 4'(m - 6'd10) : m[3:0];
        conv = {(h >= 6'd12), 2'b00, tens, ones};
      end
    end
  endfunction

  assign fall      = vs_p1 & ~vs_p0;
  assign abort_now = abort_q | vs_p0;
  assign skip      = in_edit(FSMedit, idx);
  assign timeout   = (timer == TW'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (fall) state_nxt = SEL;
      SEL:   state_nxt = abort_now ? IDLE : (skip ? NEXT : REQ);
      REQ: begin
        if (rtc_ack)      state_nxt = abort_now ? IDLE : WRITE;
        else if (timeout) state_nxt = abort_now ? IDLE : NEXT;
      end
      WRITE: state_nxt = NEXT;
      NEXT:  state_nxt = abort_now ? IDLE : ((idx == 4'd8) ? DONE : SEL);
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy                 = (state != IDLE) && (state != DONE);
    rtc_req              = (state == REQ);
    rtc_addr             = rtc_req ? addr_of(idx) : 8'h00;
    control_dato_lectura = (state == WRITE) && !abort_now;
    posicion             = control_dato_lectura ? idx : 4'd9;
    frame_done           = (state == DONE);
  end

  // v_sync sampling, sequence bookkeeping and captured write data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_p0    <= 1'b0;
      vs_p1    <= 1'b0;
      idx      <= 4'd0;
      timer    <= '0;
      abort_q  <= 1'b0;
      rtc_err  <= 1'b0;
      data_out <= 8'h00;
    end else begin
      vs_p0 <= v_sync;
      vs_p1 <= vs_p0;
      timer <= (state == REQ) ? timer + 1'b1 : '0;
      if (state == IDLE && fall) begin
        idx     <= 4'd0;
        rtc_err <= 1'b0;
        abort_q <= 1'b0;
      end else if (busy && vs_p0) begin
        abort_q <= 1'b1;
      end
      if (state == NEXT && !abort_now && idx != 4'd8) idx <= idx + 4'd1;
      if (state == REQ && !rtc_ack && timeout) rtc_err <= 1'b1;
      if (state == REQ && rtc_ack && !abort_now) data_out <= conv(idx, rtc_rdata, sw_formato);
    end
  end

endmodule

// File: tb/tb_rtc_refresh_sequencer.sv
// Randomized bench for rtc_refresh_sequencer: an RTC responder model feeds the handshake and a
// per-frame reference model predicts the bank writes, request addresses and error flag.
module tb_rtc_refresh_sequencer;

  logic       clk = 1'b0;
  logic       reset, v_sync, sw_formato, rtc_ack;
  logic [1:0] FSMedit;
  logic [7:0] rtc_rdata;
  logic       rtc_req, control_dato_lectura, busy, frame_done, rtc_err;
  logic [7:0] rtc_addr, data_out;
  logic [3:0] posicion;

  rtc_refresh_sequencer dut (
    .clk(clk), .reset(reset), .v_sync(v_sync), .sw_formato(sw_formato), .FSMedit(FSMedit),
    .rtc_ack(rtc_ack), .rtc_rdata(rtc_rdata), .rtc_req(rtc_req), .rtc_addr(rtc_addr),
    .posicion(posicion), .data_out(data_out), .control_dato_lectura(control_dato_lectura),
    .busy(busy), .frame_done(frame_done), .rtc_err(rtc_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem [256];
  int          ack_delay = 0;
  logic        noack_en = 1'b0;
  logic [7:0]  noack_addr = 8'h00;

  logic [11:0] got_wr[$];
  logic [7:0]  got_addr[$];
  int          req_lens[$];
  int          done_cnt;
  logic        pos_bad;

  logic [11:0] exp_wr[$];
  logic [7:0]  exp_addr[$];
  logic        exp_err;

  logic [7:0] addr_tab [9] = '{8'h21, 8'h22, 8'h23, 8'h26, 8'h25, 8'h24, 8'h41, 8'h42, 8'h43};

  // RTC responder and bus monitor, both working on the falling clock edge.
  initial begin
    int   wait_cnt;
    int   req_len;
    logic req_prev;
    wait_cnt = 0; req_len = 0; req_prev = 1'b0;
    rtc_ack = 1'b0; rtc_rdata = 8'h00;
    done_cnt = 0; pos_bad = 1'b0;
    forever begin
      @(negedge clk);
      if (control_dato_lectura) got_wr.push_back({posicion, data_out});
      else if (posicion !== 4'd9) pos_bad = 1'b1;
      if (frame_done) done_cnt++;
      if (rtc_req && !req_prev) got_addr.push_back(rtc_addr);
      if (rtc_req) req_len++;
      else if (req_prev) begin
        req_lens.push_back(req_len);
        req_len = 0;
      end
      req_prev = rtc_req;
      rtc_ack = 1'b0;
      if (rtc_req) begin
        if (wait_cnt == ack_delay && !(noack_en && rtc_addr == noack_addr)) begin
          rtc_ack   = 1'b1;
          rtc_rdata = mem[rtc_addr];
        end
        wait_cnt++;
      end else begin
        wait_cnt = 0;
      end
    end
  end

  function automatic logic [7:0] conv_ref(input int i, input logic [7:0] b, input logic fmt);
    int h, h12;
    if (i != 2) return b;
    if (!fmt || b > 8'h23) return {1'b0, b[6:0]};
    h   = int'(b[5:4]) * 10 + int'(b[3:0]);
    h12 = (h % 12 == 0) ? 12 : h % 12;
    return {(h >= 12), 3'(h12 / 10), 4'(h12 % 10)};
  endfunction

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Positions are visited in order; groups are hora(0-2)=3, fecha(3-5)=2, timer(6-8)=1.
  task automatic build_expected(input int stop_pos);
    exp_wr.delete(); exp_addr.delete(); exp_err = 1'b0;
    for (int i = 0; i < 9; i++) begin
      logic [7:0] a;
      if (int'(FSMedit) == 3 - i / 3) continue;
      if (i > stop_pos) break;
      a = addr_tab[i];
      exp_addr.push_back(a);
      if (noack_en && a == noack_addr) begin
        exp_err = 1'b1;
        continue;
      end
      if (i < stop_pos) exp_wr.push_back({4'(i), conv_ref(i, mem[a], sw_formato)});
    end
  endtask

  task automatic randomize_mem();
    foreach (addr_tab[i]) mem[addr_tab[i]] = 8'($urandom_range(0, 255));
    if (sw_formato) mem[8'h23] = ($urandom_range(0, 3) == 0) ? bcd($urandom_range(24, 39))
                                                             : bcd($urandom_range(0, 23));
  endtask

  task automatic clear_obs();
    got_wr.delete(); got_addr.delete(); req_lens.delete();
    done_cnt = 0; pos_bad = 1'b0;
  endtask

  task automatic run_frame(output logic err_start);
    int n;
    clear_obs();
    v_sync = 1'b1;
    repeat (3) @(negedge clk);
    v_sync = 1'b0;
    n = 0;
    while (!busy && n < 10) begin @(negedge clk); n++; end
    err_start = rtc_err;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL frame_start: busy=%b required 1", busy); end
    n = 0;
    while (busy && n < 6000) begin @(negedge clk); n++; end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL frame_end: busy=%b required 0", busy); end
    repeat (2) @(negedge clk);
    v_sync = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; v_sync = 1'b1; sw_formato = 1'b0; FSMedit = 2'd0;
    foreach (mem[i]) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (rtc_req !== 1'b0) begin failures++; $display("FAIL rst_req: got %b required 0", rtc_req); end
    checks++; if (rtc_addr !== 8'h00) begin failures++; $display("FAIL rst_addr: got %h required 00", rtc_addr); end
    checks++; if (posicion !== 4'd9) begin failures++; $display("FAIL rst_pos: got %0d required 9", posicion); end
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL rst_data: got %h required 00", data_out); end
    checks++; if (control_dato_lectura !== 1'b0) begin failures++; $display("FAIL rst_strobe: got %b required 0", control_dato_lectura); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b required 0", busy); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL rst_done: got %b required 0", frame_done); end
    checks++; if (rtc_err !== 1'b0) begin failures++; $display("FAIL rst_err: got %b required 0", rtc_err); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] bytes [9] = '{8'h45, 8'h30, 8'h23, 8'h24, 8'h07, 8'h15, 8'h10, 8'h05, 8'h00};
    logic err_s;
    ack_delay = 2; FSMedit = 2'd0; sw_formato = 1'b0; noack_en = 1'b0;
    foreach (addr_tab[i]) mem[addr_tab[i]] = bytes[i];
    run_frame(err_s);
    checks++;
    if (got_wr.size() != 9) begin failures++; $display("FAIL basic_nwr: got %0d required 9", got_wr.size()); end
    else foreach (got_wr[i]) begin
      checks++;
      if (got_wr[i] !== {4'(i), bytes[i]}) begin
        failures++; $display("FAIL basic_wr[%0d]: got %h required %h", i, got_wr[i], {4'(i), bytes[i]});
      end
    end
    checks++;
    if (got_addr.size() != 9) begin failures++; $display("FAIL basic_naddr: got %0d required 9", got_addr.size()); end
    else foreach (got_addr[i]) begin
      checks++;
      if (got_addr[i] !== addr_tab[i]) begin
        failures++; $display("FAIL basic_addr[%0d]: got %h required %h", i, got_addr[i], addr_tab[i]);
      end
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL basic_done: got %0d required 1", done_cnt); end
    checks++; if (rtc_err !== 1'b0) begin failures++; $display("FAIL basic_err: got %b required 0", rtc_err); end
  endtask

  task automatic test_hour_format();
    logic [7:0] hrs [5] = '{8'h00, 8'h12, 8'h13, 8'h21, 8'h09};
    logic [7:0] req [5] = '{8'h12, 8'h92, 8'h81, 8'h89, 8'h09};
    logic err_s;
    sw_formato = 1'b1; FSMedit = 2'd0; ack_delay = 1;
    for (int k = 0; k < 5; k++) begin
      logic [7:0] seen;
      seen = 8'hxx;
      mem[8'h23] = hrs[k];
      run_frame(err_s);
      foreach (got_wr[i]) if (got_wr[i][11:8] == 4'd2) seen = got_wr[i][7:0];
      checks++;
      if (seen !== req[k]) begin
        failures++; $display("FAIL hour12[%h]: got %h required %h", hrs[k], seen, req[k]);
      end
      checks++; if (done_cnt != 1) begin failures++; $display("FAIL hour12_done: got %0d required 1", done_cnt); end
    end
  endtask

  task automatic test_skip();
    logic err_s;
    FSMedit = 2'd2; sw_formato = 1'($urandom_range(0, 1)); ack_delay = 0; noack_en = 1'b0;
    randomize_mem();
    build_expected(9);
    run_frame(err_s);
    checks++;
    if (got_wr.size() != exp_wr.size()) begin failures++; $display("FAIL skip_nwr: got %0d required %0d", got_wr.size(), exp_wr.size()); end
    else foreach (exp_wr[i]) begin
      checks++;
      if (got_wr[i] !== exp_wr[i]) begin failures++; $display("FAIL skip_wr[%0d]: got %h required %h", i, got_wr[i], exp_wr[i]); end
    end
    checks++;
    if (got_addr.size() != exp_addr.size()) begin failures++; $display("FAIL skip_naddr: got %0d required %0d", got_addr.size(), exp_addr.size()); end
    else foreach (exp_addr[i]) begin
      checks++;
      if (got_addr[i] !== exp_addr[i]) begin failures++; $display("FAIL skip_addr[%0d]: got %h required %h", i, got_addr[i], exp_addr[i]); end
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL skip_done: got %0d required 1", done_cnt); end
  endtask

  task automatic test_timeout();
    logic err_s;
    FSMedit = 2'd0; sw_formato = 1'b0; ack_delay = $urandom_range(0, 3);
    noack_en = 1'b1; noack_addr = 8'h22;
    randomize_mem();
    build_expected(9);
    run_frame(err_s);
    checks++;
    if (got_wr.size() != exp_wr.size()) begin failures++; $display("FAIL tmo_nwr: got %0d required %0d", got_wr.size(), exp_wr.size()); end
    else foreach (exp_wr[i]) begin
      checks++;
      if (got_wr[i] !== exp_wr[i]) begin failures++; $display("FAIL tmo_wr[%0d]: got %h required %h", i, got_wr[i], exp_wr[i]); end
    end
    checks++;
    if (req_lens.size() < 2) begin failures++; $display("FAIL tmo_nreq: got %0d required >=2", req_lens.size()); end
    else begin
      checks++;
      if (req_lens[1] != 255) begin failures++; $display("FAIL tmo_reqlen: got %0d required 255", req_lens[1]); end
    end
    checks++; if (rtc_err !== exp_err) begin failures++; $display("FAIL tmo_err: got %b required %b", rtc_err, exp_err); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL tmo_done: got %0d required 1", done_cnt); end
    noack_en = 1'b0;
    build_expected(9);
    run_frame(err_s);
    checks++; if (err_s !== 1'b0) begin failures++; $display("FAIL tmo_errclr: got %b required 0", err_s); end
    checks++; if (got_wr.size() != 9) begin failures++; $display("FAIL tmo_next_nwr: got %0d required 9", got_wr.size()); end
    checks++; if (rtc_err !== 1'b0) begin failures++; $display("FAIL tmo_next_err: got %b required 0", rtc_err); end
  endtask

  task automatic test_abort();
    int n;
    FSMedit = 2'd0; sw_formato = 1'($urandom_range(0, 1)); ack_delay = 3; noack_en = 1'b0;
    randomize_mem();
    build_expected(4);
    clear_obs();
    v_sync = 1'b1;
    repeat (3) @(negedge clk);
    v_sync = 1'b0;
    n = 0;
    while (!(rtc_req && rtc_addr == 8'h25) && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (!(rtc_req && rtc_addr == 8'h25)) begin failures++; $display("FAIL abort_reach: req=%b addr=%h required 1/25", rtc_req, rtc_addr); end
    v_sync = 1'b1;
    n = 0;
    while (busy && n < 300) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    checks++;
    if (got_wr.size() != exp_wr.size()) begin failures++; $display("FAIL abort_nwr: got %0d required %0d", got_wr.size(), exp_wr.size()); end
    else foreach (exp_wr[i]) begin
      checks++;
      if (got_wr[i] !== exp_wr[i]) begin failures++; $display("FAIL abort_wr[%0d]: got %h required %h", i, got_wr[i], exp_wr[i]); end
    end
    checks++;
    if (got_addr.size() != exp_addr.size()) begin failures++; $display("FAIL abort_naddr: got %0d required %0d", got_addr.size(), exp_addr.size()); end
    checks++; if (done_cnt != 0) begin failures++; $display("FAIL abort_done: got %0d required 0", done_cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b required 0", busy); end
    checks++; if (posicion !== 4'd9) begin failures++; $display("FAIL abort_pos: got %0d required 9", posicion); end
    checks++; if (pos_bad !== 1'b0) begin failures++; $display("FAIL abort_idlepos: got %b required 0", pos_bad); end
  endtask

  task automatic test_reset_mid();
    int n;
    logic err_s;
    FSMedit = 2'd0; sw_formato = 1'b0; ack_delay = 3; noack_en = 1'b0;
    clear_obs();
    v_sync = 1'b1;
    repeat (3) @(negedge clk);
    v_sync = 1'b0;
    n = 0;
    while (!rtc_req && n < 50) begin @(negedge clk); n++; end
    #2 reset = 1'b1;
    #1;
    checks++; if (rtc_req !== 1'b0) begin failures++; $display("FAIL rmid_req: got %b required 0", rtc_req); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy: got %b required 0", busy); end
    checks++; if (control_dato_lectura !== 1'b0) begin failures++; $display("FAIL rmid_strobe: got %b required 0", control_dato_lectura); end
    checks++; if (posicion !== 4'd9) begin failures++; $display("FAIL rmid_pos: got %0d required 9", posicion); end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    randomize_mem();
    build_expected(9);
    run_frame(err_s);
    checks++;
    if (got_addr.size() == 0 || got_addr[0] !== 8'h21) begin
      failures++; $display("FAIL rmid_first_addr: got %h required 21", (got_addr.size() == 0) ? 8'hxx : got_addr[0]);
    end
    checks++;
    if (got_wr.size() != exp_wr.size()) begin failures++; $display("FAIL rmid_nwr: got %0d required %0d", got_wr.size(), exp_wr.size()); end
    else foreach (exp_wr[i]) begin
      checks++;
      if (got_wr[i] !== exp_wr[i]) begin failures++; $display("FAIL rmid_wr[%0d]: got %h required %h", i, got_wr[i], exp_wr[i]); end
    end
  endtask

  task automatic test_random();
    logic err_s;
    noack_en = 1'b0;
    for (int f = 0; f < 15; f++) begin
      FSMedit = 2'($urandom_range(0, 3)); sw_formato = 1'($urandom_range(0, 1));
      ack_delay = $urandom_range(0, 3);
      randomize_mem();
      build_expected(9);
      run_frame(err_s);
      checks++;
      if (got_wr.size() != exp_wr.size()) begin failures++; $display("FAIL rand%0d_nwr: got %0d required %0d", f, got_wr.size(), exp_wr.size()); end
      else foreach (exp_wr[i]) begin
        checks++;
        if (got_wr[i] !== exp_wr[i]) begin failures++; $display("FAIL rand%0d_wr[%0d]: got %h required %h", f, i, got_wr[i], exp_wr[i]); end
      end
      checks++;
      if (got_addr.size() != exp_addr.size()) begin failures++; $display("FAIL rand%0d_naddr: got %0d required %0d", f, got_addr.size(), exp_addr.size()); end
      else foreach (exp_addr[i]) begin
        checks++;
        if (got_addr[i] !== exp_addr[i]) begin failures++; $display("FAIL rand%0d_addr[%0d]: got %h required %h", f, i, got_addr[i], exp_addr[i]); end
      end
      checks++; if (done_cnt != 1) begin failures++; $display("FAIL rand%0d_done: got %0d required 1", f, done_cnt); end
      checks++; if (pos_bad !== 1'b0) begin failures++; $display("FAIL rand%0d_idlepos: got %b required 0", f, pos_bad); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hour_format();
    test_skip();
    test_timeout();
    test_abort();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
